io_clk_meas: RTL

IO_CLK_MEAS -- requirements
Module: io_clk_meas

---
 rtl/io_clk_meas.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/io_clk_meas.sv
// rtl/io_clk_meas.sv - half-period measurement of an asynchronous signal with an IO register window
//
// Measures the high and low half-periods of ASigI in AClkH cycles. The signal is
// synchronized, and edge-to-edge distances are captured into HiLen/LoLen.
// Optional feature macro: IO_CLK_MEAS_IRQ_EN (drives AIrq; without it AIrq is 0).
//
// Ports:
//   AClkH      - clock, rising edge
//   AResetHN   - asynchronous active-low reset
//   AClkHEn    - clock enable, all state holds while low
//   AIoAddr    - IO byte address
//   AIoMosi    - IO write data, bits [7:0] used
//   AIoWrSize  - write size one-hot (1/2/4/8 bytes), 0 = no write
//   AIoRdSize  - read size one-hot, 0 = no read
//   AIoMiso    - combinational read data, 0 unless a legal read is in progress
//   AIoAddrAck - legal access inside the window
//   AIoAddrErr - illegal access inside the window
//   ASigI      - asynchronous signal to measure
//   AIrq       - one-cycle pulse when a complete {HiLen, LoLen} pair is stored
module io_clk_meas #(
  parameter logic [15:0] CAddrBase = 16'h0000,
  parameter int unsigned CCntW     = 16
) (
  input  logic        AClkH,
  input  logic        AResetHN,
  input  logic        AClkHEn,
  input  logic [15:0] AIoAddr,
  input  logic [63:0] AIoMosi,
  input  logic [3:0]  AIoWrSize,
  input  logic [3:0]  AIoRdSize,
  output logic [63:0] AIoMiso,
  output logic        AIoAddrAck,
  output logic        AIoAddrErr,
  input  logic        ASigI,
  output logic        AIrq
);

  typedef enum logic [1:0] {SIdle, SSync, SMeasLo, SMeasHi} state_e;

  localparam logic [CCntW-1:0] CntMax = '1;

  state_e             state_q;
  logic               en_q;
  logic               valid_q, ovf_q, lo_seen_q;
  logic [CCntW-1:0]   hi_len_q, lo_len_q;
  logic [CCntW-1:0]   cnt_q, cnt_d;
  logic               s1_q, s2_q, s3_q;

  // Only the low byte of the write bus carries control bits.
  logic unused_mosi;
  assign unused_mosi = ^AIoMosi[63:8];

  // ---------------- IO decode ----------------
  logic [15:0] off;
  logic        in_win, at_ctl, has_access, wr_ok, rd_ok, ctl_wr;

  assign off        = AIoAddr - CAddrBase;
  assign in_win     = (off[15:2] == 14'd0);
  assign at_ctl     = (off[1:0] == 2'd0);
  assign has_access = (AIoWrSize != 4'd0) || (AIoRdSize != 4'd0);
  assign wr_ok      = (AIoWrSize == 4'd0) || (at_ctl && AIoWrSize == 4'b0001);
  assign rd_ok      = (AIoRdSize == 4'd0) ||
                      (at_ctl && (AIoRdSize == 4'b0001 || AIoRdSize == 4'b0100));
  assign AIoAddrAck = in_win && has_access && wr_ok && rd_ok;
  assign AIoAddrErr = in_win && has_access && !(wr_ok && rd_ok);
  assign ctl_wr     = AIoAddrAck && (AIoWrSize == 4'b0001);

  logic        busy;
  logic [15:0] hi16, lo16;
  assign busy = (state_q != SIdle);
  assign hi16 = 16'(hi_len_q);
  assign lo16 = 16'(lo_len_q);

  // Reads see the current registers, so a same-cycle control write returns pre-write data.
  always_comb begin
    AIoMiso = 64'd0;
    if (AIoAddrAck && AIoRdSize == 4'b0001)
      AIoMiso[7:0] = {5'b0, ovf_q, busy, valid_q};
    else if (AIoAddrAck && AIoRdSize == 4'b0100)
      AIoMiso[31:0] = {hi16, lo16};
  end

  // ---------------- synchronizer, edge detect, counter ----------------
  logic rise, fall, sig_edge;
  assign rise     = s2_q & ~s3_q;
  assign fall     = ~s2_q & s3_q;
  assign sig_edge = rise | fall;

  always_comb begin
    cnt_d = cnt_q;
    if (sig_edge)
      cnt_d = '0;
    else if (cnt_q != CntMax)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      cnt_q <= '0;
    end else if (AClkHEn) begin
      s1_q  <= ASigI;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      cnt_q <= cnt_d;
    end
  end

  // ---------------- measurement FSM ----------------
  logic clr, run, in_meas, ovf_hit, lo_store, hi_store;
  assign clr      = ctl_wr && AIoMosi[1];
  // Clr has priority over any edge seen in the same cycle.
  assign run      = en_q && !clr;
  assign in_meas  = (state_q == SMeasLo) || (state_q == SMeasHi);
  // Saturation means the half-period no longer fits; it wins over a coincident edge.
  assign ovf_hit  = run && in_meas && (cnt_q == CntMax);
  assign lo_store = run && (state_q == SMeasLo) && !ovf_hit && rise;
  assign hi_store = run && (state_q == SMeasHi) && !ovf_hit && fall;

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state_q   <= SIdle;
      en_q      <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      lo_seen_q <= 1'b0;
      hi_len_q  <= '0;
      lo_len_q  <= '0;
    end else if (AClkHEn) begin
      if (ctl_wr)
        en_q <= AIoMosi[0];
      if (clr) begin
        valid_q   <= 1'b0;
        ovf_q     <= 1'b0;
        lo_seen_q <= 1'b0;
        hi_len_q  <= '0;
        lo_len_q  <= '0;
        state_q   <= AIoMosi[0] ? SSync : SIdle;
      end else if (!en_q) begin
        state_q   <= SIdle;
        lo_seen_q <= 1'b0;
      end else if (ovf_hit) begin
        ovf_q     <= 1'b1;
        lo_seen_q <= 1'b0;
        state_q   <= SSync;
      end else begin
        unique case (state_q)
          SIdle:   state_q <= SSync;
          // The interval leading up to the first edge is partial and discarded.
          SSync: begin
            if (rise)
              state_q <= SMeasHi;
            else if (fall)
              state_q <= SMeasLo;
          end
          SMeasLo: begin
            if (lo_store) begin
              lo_len_q  <= cnt_q + 1'b1;
              lo_seen_q <= 1'b1;
              state_q   <= SMeasHi;
            end
          end
          SMeasHi: begin
            if (hi_store) begin
              hi_len_q <= cnt_q + 1'b1;
              state_q  <= SMeasLo;
              if (lo_seen_q)
                valid_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef IO_CLK_MEAS_IRQ_EN
  logic irq_q;
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN)
      irq_q <= 1'b0;
    else if (AClkHEn)
      irq_q <= hi_store && lo_seen_q;
  end
  assign AIrq = irq_q;
`else
  assign AIrq = 1'b0;
`endif

endmodule
